// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI3 SRAM slave: channel widths, burst and
// response encodings, read/write FSM state types, and the burst address
// stepping helper used by both channels.
package axi_slave_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Address of the next beat. WRAP is stepped like INCR (no wrap boundary);
  // FIXED and the reserved encoding hold the address. Wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    case (burst)
      BURST_INCR, BURST_WRAP: return addr + (32'd1 << size);
      BURST_FIXED:            return addr;
      default:                return addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Word-organised SRAM for the AXI slave.
//   aclk/areset      : clock, synchronous active-high reset (output register only)
//   rd_en/rd_addr    : synchronous read; rd_data is registered and holds
//                      its value while rd_en is low
//   we/wr_addr/wr_be : byte-enabled synchronous write
// A read and a write to the same word on the same edge return the old data.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [STRB_W-1:0] wr_be,
  input  logic [DATA_W-1:0] wr_data
);

  // Contents are deliberately not reset.
  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge aclk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by on-chip SRAM. Independent read and write FSMs, one
// outstanding transaction per direction, bursts of up to 16 beats.
//   aclk, areset             : clock, synchronous active-high reset
//   ar* / r*                 : read address and read data channels
//   aw* / w* / b*            : write address, write data, write response
//   *lock/*cache/*prot, wid  : accepted and ignored
// Address bits [MEM_WORDS_LOG2+1:2] select the word; upper bits alias.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int IW = MEM_WORDS_LOG2;

  // ---------------- read channel ----------------
  rd_state_e         r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len, r_beat;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              ar_hs, r_hs, rd_en;
  logic [ADDR_W-1:0] rd_addr_full;

  assign ar_hs  = arvalid && arready;
  assign rvalid = (r_state == R_DATA);
  assign rlast  = rvalid && (r_beat == r_len);
  assign rresp  = RESP_OKAY;
  assign r_hs   = rvalid && rready;

  // The data register is loaded on the AR handshake and on every accepted
  // non-final beat, so it only changes when the master has taken the beat.
  assign rd_en        = ar_hs || (r_hs && !rlast);
  assign rd_addr_full = ar_hs ? araddr : next_addr(r_addr, r_size, r_burst);

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
      R_DATA:  if (r_hs && rlast) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // arready is a flop so it stays low through reset and rises one edge after.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      arready <= (r_state_nx == R_IDLE);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (ar_hs) begin
      rid     <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_beat  <= '0;
      r_size  <= arsize;
      r_burst <= arburst;
    end else if (r_hs && !rlast) begin
      r_addr  <= rd_addr_full;
      r_beat  <= r_beat + 1'b1;
    end
  end

  // ---------------- write channel ----------------
  wr_state_e         w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len, w_beat;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, aw_hs, w_hs, w_cnt_last;

  assign aw_hs      = awvalid && awready;
  assign wready     = (w_state == W_DATA);
  assign w_hs       = wvalid && wready;
  assign w_cnt_last = (w_beat == w_len);
  assign bvalid     = (w_state == W_RESP);
  assign bresp      = w_err ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_cnt_last) w_state_nx = W_RESP;
      W_RESP:  if (bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      awready <= (w_state_nx == W_IDLE);
    end
  end

  // The burst length comes from awlen; wlast is only cross-checked against
  // the beat counter and a disagreement on any beat turns the response into
  // SLVERR.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        bid     <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_beat  <= '0;
        w_size  <= awsize;
        w_burst <= awburst;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_size, w_burst);
        w_beat <= w_beat + 1'b1;
        if (wlast != w_cnt_last) w_err <= 1'b1;
      end
      if (bvalid && bready) w_err <= 1'b0;
    end
  end

  // ---------------- storage ----------------
  axi_slave_mem #(.AW(IW)) u_mem (
    .aclk    (aclk),
    .areset  (areset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_full[IW+1:2]),
    .rd_data (rdata),
    .we      (w_hs),
    .wr_addr (w_addr[IW+1:2]),
    .wr_be   (wstrb),
    .wr_data (wdata)
  );

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       rd_addr_full[ADDR_W-1:IW+2], rd_addr_full[1:0]};

endmodule
